// File: rtl/ftdi_fsi_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkg
// Description : Shared constants and state encodings for the FTDI FT2232
//               fast-serial-interface link.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    // start bit + 8 data bits + channel bit
    localparam int   FSI_FRAME_BITS = 10;
    localparam logic FSI_CH_A       = 1'b0;
    localparam logic FSI_CH_B       = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE     = 2'd0,
        TX_WAIT_CTS = 2'd1,
        TX_SHIFT    = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_DATA = 2'd1,
        RX_CHAN = 2'd2
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/ftdi_fsi_link_if.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_fsi_link_if
// Description : Bundles the FTDI pins and the host-side byte handshake of the
//               FSI link. Names carry the direction seen from the link.
//   slave  : the link itself (drives o_*, consumes i_*)
//   master : FTDI device + host logic (drives i_*, consumes o_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface ftdi_fsi_link_if;
    logic       o_ftdi_clk;
    logic       o_ftdi_si;
    logic       i_ftdi_so;
    logic       i_ftdi_cts;
    logic       i_rx_ready;
    logic       o_rx_valid;
    logic [7:0] o_rx_data;
    logic       o_tx_busy;
    logic       i_tx_valid;
    logic       i_tx_channel;
    logic [7:0] i_tx_data;

    modport slave (
        input  i_ftdi_so, i_ftdi_cts, i_rx_ready, i_tx_valid, i_tx_channel, i_tx_data,
        output o_ftdi_clk, o_ftdi_si, o_rx_valid, o_rx_data, o_tx_busy
    );

    modport master (
        output i_ftdi_so, i_ftdi_cts, i_rx_ready, i_tx_valid, i_tx_channel, i_tx_data,
        input  o_ftdi_clk, o_ftdi_si, o_rx_valid, o_rx_data, o_tx_busy
    );
endinterface
`default_nettype wire

// File: rtl/ftdi_fsi_link_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_fsi_clkgen
// Description : FSCLK generator. A divider counting 0..CLK_DIV-1 toggles
//               FSCLK at terminal count. o_rise / o_fall are single-cycle
//               strobes asserted in the i_clk cycle whose closing edge moves
//               FSCLK, so logic using them updates together with the pin.
//               When i_clk_en drops the clock always finishes a low phase and
//               parks high.
// Ports       : i_clk, i_reset, i_clk_en -> o_fsclk, o_rise, o_fall
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_fsi_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  wire  i_clk,
    input  wire  i_reset,
    input  wire  i_clk_en,
    output logic o_fsclk,
    output logic o_rise,
    output logic o_fall
);
    localparam int c_CNT_W = $clog2(CLK_DIV);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_fsclk;
    logic               w_tc;
    logic               w_run;

    assign w_tc  = (r_cnt == c_CNT_W'(CLK_DIV - 1));
    // A low FSCLK keeps running regardless of the enable: it may only stop high.
    assign w_run = i_clk_en | ~r_fsclk;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_fsclk <= 1'b1;
        end else if (w_run) begin
            if (w_tc) begin
                r_cnt   <= '0;
                r_fsclk <= ~r_fsclk;
            end else begin
                r_cnt   <= r_cnt + c_CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_fsclk = r_fsclk;
    assign o_rise  = w_run & w_tc & ~r_fsclk;
    assign o_fall  = w_run & w_tc &  r_fsclk;
endmodule
`default_nettype wire

// File: rtl/ftdi_fsi_link.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_fsi_link
// Description : FT2232 fast-serial-interface engine. Serializes bytes onto
//               FSDI (changed on FSCLK falling edges) and deserializes FSDO
//               (sampled on rising edges). Frame: start 0, d0..d7, channel.
// Ports       : i_clk, i_reset (sync, active high), bus (ftdi_fsi_link_if.slave)
// Parameters  : CLK_DIV    - i_clk cycles per FSCLK half period (>=2)
//               RX_CHANNEL - channel accepted by the optional RX filter
// Options     : FTDI_FSI_RX_CHANNEL_FILTER_EN - drop RX frames whose channel
//               bit differs from RX_CHANNEL
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_fsi_link
    import usb_pkg::*;
#(
    parameter int   CLK_DIV    = 2,
    parameter logic RX_CHANNEL = FSI_CH_A
) (
    input  wire            i_clk,
    input  wire            i_reset,
    ftdi_fsi_link_if.slave bus
);
    // ---------------- synchronizers -----------------------------------------
    logic r_so_s1, r_so_s2, r_cts_s1, r_cts_s2;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_so_s1  <= 1'b1;
            r_so_s2  <= 1'b1;
            r_cts_s1 <= 1'b0;
            r_cts_s2 <= 1'b0;
        end else begin
            r_so_s1  <= bus.i_ftdi_so;
            r_so_s2  <= r_so_s1;
            r_cts_s1 <= bus.i_ftdi_cts;
            r_cts_s2 <= r_cts_s1;
        end
    end

    // ---------------- state -------------------------------------------------
    tx_state_t  r_tx_state, w_tx_state_nx;
    logic [8:0] r_tx_sr,    w_tx_sr_nx;
    logic [3:0] r_tx_cnt,   w_tx_cnt_nx;
    logic       r_tx_si,    w_tx_si_nx;

    rx_state_t  r_rx_state, w_rx_state_nx;
    logic [7:0] r_rx_sr,    w_rx_sr_nx;
    logic [2:0] r_rx_cnt,   w_rx_cnt_nx;
    logic [7:0] r_rx_data,  w_rx_data_nx;
    logic       r_rx_valid, w_rx_valid_nx;

    logic w_fsclk, w_rise, w_fall, w_clk_en, w_ch_accept;

    assign w_clk_en = bus.i_rx_ready | (r_tx_state != TX_IDLE) | (r_rx_state != RX_IDLE);

    ftdi_fsi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clk_en (w_clk_en),
        .o_fsclk  (w_fsclk),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

`ifdef FTDI_FSI_RX_CHANNEL_FILTER_EN
    assign w_ch_accept = (r_so_s2 == RX_CHANNEL);
`else
    // Channel bit is ignored; the compare only keeps RX_CHANNEL referenced.
    assign w_ch_accept = (r_so_s2 == RX_CHANNEL) | 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_sr    <= '0;
            r_tx_cnt   <= '0;
            r_tx_si    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_sr    <= '0;
            r_rx_cnt   <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_sr    <= w_tx_sr_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_si    <= w_tx_si_nx;
            r_rx_state <= w_rx_state_nx;
            r_rx_sr    <= w_rx_sr_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_data  <= w_rx_data_nx;
            r_rx_valid <= w_rx_valid_nx;
        end
    end

    // ---------------- TX next state -----------------------------------------
    // The start bit leaves in WAIT_CTS; SHIFT then spends 9 falling edges on
    // d0..d7 + channel and a 10th restoring the idle-high line.
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_sr_nx    = r_tx_sr;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_si_nx    = r_tx_si;
        case (r_tx_state)
            TX_IDLE: begin
                if (bus.i_tx_valid) begin
                    w_tx_sr_nx    = {bus.i_tx_channel, bus.i_tx_data};
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = TX_WAIT_CTS;
                end
            end
            TX_WAIT_CTS: begin
                if (w_fall && r_cts_s2) begin
                    w_tx_si_nx    = 1'b0;
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (w_fall) begin
                    if (r_tx_cnt == 4'(FSI_FRAME_BITS - 1)) begin
                        w_tx_si_nx    = 1'b1;
                        w_tx_state_nx = TX_IDLE;
                    end else begin
                        w_tx_si_nx  = r_tx_sr[0];
                        w_tx_sr_nx  = {1'b0, r_tx_sr[8:1]};
                        w_tx_cnt_nx = r_tx_cnt + 4'd1;
                    end
                end
            end
            default: w_tx_state_nx = TX_IDLE;
        endcase
    end

    // ---------------- RX next state -----------------------------------------
    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_sr_nx    = r_rx_sr;
        w_rx_cnt_nx   = r_rx_cnt;
        w_rx_data_nx  = r_rx_data;
        w_rx_valid_nx = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                // i_rx_ready gates only the start; a frame in flight finishes.
                if (w_rise && !r_so_s2 && bus.i_rx_ready) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_state_nx = RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rise) begin
                    w_rx_sr_nx  = {r_so_s2, r_rx_sr[7:1]};
                    w_rx_cnt_nx = r_rx_cnt + 3'd1;
                    if (r_rx_cnt == 3'd7) begin
                        w_rx_state_nx = RX_CHAN;
                    end
                end
            end
            RX_CHAN: begin
                if (w_rise) begin
                    w_rx_state_nx = RX_IDLE;
                    if (w_ch_accept) begin
                        w_rx_data_nx  = r_rx_sr;
                        w_rx_valid_nx = 1'b1;
                    end
                end
            end
            default: w_rx_state_nx = RX_IDLE;
        endcase
    end

    assign bus.o_ftdi_clk = w_fsclk;
    assign bus.o_ftdi_si  = r_tx_si;
    assign bus.o_tx_busy  = (r_tx_state != TX_IDLE);
    assign bus.o_rx_valid = r_rx_valid;
    assign bus.o_rx_data  = r_rx_data;
endmodule
`default_nettype wire

// File: tb/tb_ftdi_fsi_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_ftdi_fsi_link
// Description : Self-checking bench for ftdi_fsi_link. An FTDI-side model
//               drives FSDO and decodes FSDI; expected frames/bytes are queued
//               at stimulus time and popped by independent monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ftdi_fsi_link;
    import usb_pkg::*;

    localparam int   CLK_DIV = 2;
    localparam logic RX_CH   = FSI_CH_A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ftdi_fsi_link_if bus ();

    ftdi_fsi_link #(
        .CLK_DIV    (CLK_DIV),
        .RX_CHANNEL (RX_CH)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int         compared   = 0;
    int         mismatched = 0;
    int         rx_strobes = 0;
    logic [8:0] tx_q[$];
    logic [7:0] rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got timeout, expected event", name);
    endtask

    // Waits (on negedges) until FSCLK has been seen going high.
    task automatic wait_rise(input int limit);
        logic prev;
        bit   seen;
        prev = bus.o_ftdi_clk;
        seen = 0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            if (!prev && bus.o_ftdi_clk) seen = 1;
            prev = bus.o_ftdi_clk;
        end
        if (!seen) timeout_fail("fsclk_rise");
    endtask

    // FTDI model: each bit is placed just after an FSCLK rise so it is long
    // settled through the synchronizer before the next rise samples it.
    task automatic rx_send(input logic ch, input logic [7:0] data);
        logic [9:0] f;
        f = {ch, data, 1'b0};
        wait_rise(2000);
        for (int i = 0; i < FSI_FRAME_BITS; i++) begin
            bus.i_ftdi_so = f[i];
            wait_rise(2000);
        end
        bus.i_ftdi_so = 1'b1;
    endtask

    task automatic expect_rx(input logic ch, input logic [7:0] data);
`ifdef FTDI_FSI_RX_CHANNEL_FILTER_EN
        if (ch == RX_CH) rx_q.push_back(data);
`else
        rx_q.push_back(data);
`endif
    endtask

    task automatic send_tx(input logic ch, input logic [7:0] data);
        int n;
        n = 0;
        while (bus.o_tx_busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (bus.o_tx_busy) timeout_fail("tx_busy_wait");
        bus.i_tx_valid   = 1'b1;
        bus.i_tx_channel = ch;
        bus.i_tx_data    = data;
        @(posedge clk);
        tx_q.push_back({ch, data});
        @(negedge clk);
        bus.i_tx_valid = 1'b0;
    endtask

    // ---------------- TX monitor: decode FSDI on FSCLK rises -----------------
    initial begin : mon_tx
        logic       prevclk, in_frame, post, busy_ok;
        logic [8:0] bits;
        int         n;
        prevclk = 1'b1; in_frame = 0; post = 0; busy_ok = 1; bits = '0; n = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 0;
                post     = 0;
                prevclk  = 1'b1;
            end else begin
                if (!prevclk && bus.o_ftdi_clk) begin
                    if (post) begin
                        check("tx_idle_bit", bus.o_ftdi_si, 1);
                        post = 0;
                    end else if (!in_frame) begin
                        if (bus.o_ftdi_si == 1'b0) begin
                            in_frame = 1; n = 0; bits = '0;
                            busy_ok  = bus.o_tx_busy;
                        end
                    end else begin
                        bits[n] = bus.o_ftdi_si;
                        busy_ok = busy_ok & bus.o_tx_busy;
                        n++;
                        if (n == 9) begin
                            in_frame = 0;
                            post     = 1;
                            check("tx_busy_in_frame", busy_ok, 1);
                            if (tx_q.size() == 0) begin
                                mismatched++; compared++;
                                $display("FAIL tx_frame: got unexpected frame 0x%0h, expected none", bits);
                            end else begin
                                check("tx_frame", bits, tx_q.pop_front());
                            end
                        end
                    end
                end
                prevclk = bus.o_ftdi_clk;
            end
        end
    end

    // ---------------- RX monitor --------------------------------------------
    initial begin : mon_rx
        forever begin
            @(negedge clk);
            if (!rst && bus.o_rx_valid) begin
                rx_strobes++;
                if (rx_q.size() == 0) begin
                    mismatched++; compared++;
                    $display("FAIL rx_data: got unexpected strobe 0x%0h, expected none", bus.o_rx_data);
                end else begin
                    check("rx_data", bus.o_rx_data, rx_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random stimulus ----------------------------
    initial begin : stim
        int   lat, s0, gap;
        logic ok_a, ok_b, ok_c, ok_d;
        logic ch;
        logic [7:0] d;

        bus.i_ftdi_so = 1'b1; bus.i_ftdi_cts = 1'b1; bus.i_rx_ready = 1'b0;
        bus.i_tx_valid = 1'b0; bus.i_tx_channel = 1'b0; bus.i_tx_data = '0;
        repeat (4) @(negedge clk);
        check("rst_fsclk", bus.o_ftdi_clk, 1);
        check("rst_si", bus.o_ftdi_si, 1);
        check("rst_busy", bus.o_tx_busy, 0);
        check("rst_rx_valid", bus.o_rx_valid, 0);
        check("rst_rx_data", bus.o_rx_data, 0);
        rst = 1'b0;

        // idle, not ready: clock parked high, nothing moves
        ok_a = 1; ok_b = 1; ok_c = 1; s0 = rx_strobes;
        repeat (100) begin
            @(negedge clk);
            ok_a &= bus.o_ftdi_clk; ok_b &= bus.o_ftdi_si; ok_c &= ~bus.o_tx_busy;
        end
        check("idle_fsclk_high", ok_a, 1);
        check("idle_si_high", ok_b, 1);
        check("idle_busy_low", ok_c, 1);
        check("idle_no_strobe", rx_strobes, s0);

        // TX 0xA5 ch1, CTS high: latency and busy release
        bus.i_tx_valid = 1'b1; bus.i_tx_channel = FSI_CH_B; bus.i_tx_data = 8'hA5;
        @(posedge clk);
        tx_q.push_back({FSI_CH_B, 8'hA5});
        @(negedge clk);
        bus.i_tx_valid = 1'b0;
        check("tx_busy_after_accept", bus.o_tx_busy, 1);
        lat = 1;
        while (bus.o_ftdi_si && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("tx_start_latency_le4", (lat <= 4), 1);
        lat = 0;
        while (bus.o_tx_busy && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("tx_busy_release", bus.o_tx_busy, 0);
        check("tx_si_idle_after", bus.o_ftdi_si, 1);
        repeat (10) @(negedge clk);

        // TX 0x3C stalled by CTS low
        bus.i_ftdi_cts = 1'b0;
        repeat (4) @(negedge clk);
        send_tx(FSI_CH_A, 8'h3C);
        ok_a = 1; ok_b = 1;
        repeat (50) begin
            @(negedge clk);
            ok_a &= bus.o_ftdi_si; ok_b &= bus.o_tx_busy;
        end
        check("cts_stall_si_high", ok_a, 1);
        check("cts_stall_busy", ok_b, 1);
        bus.i_ftdi_cts = 1'b1;
        lat = 0;
        while (bus.o_ftdi_si && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("cts_release_start", (lat <= 2 + 2 * CLK_DIV + 1), 1);
        while (bus.o_tx_busy && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        repeat (10) @(negedge clk);

        // RX 0x5A ch0
        bus.i_rx_ready = 1'b1;
        s0 = rx_strobes;
        expect_rx(FSI_CH_A, 8'h5A);
        rx_send(FSI_CH_A, 8'h5A);
        repeat (4) @(negedge clk);
        check("rx_5a_one_strobe", rx_strobes, s0 + 1);

        // ready falls mid-frame: 0xFF still completes, 0x11 held off
        s0 = rx_strobes;
        expect_rx(FSI_CH_A, 8'hFF);
        fork
            rx_send(FSI_CH_A, 8'hFF);
            begin
                repeat (3) wait_rise(2000);
                bus.i_rx_ready = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("rx_ff_completes", rx_strobes, s0 + 1);
        s0 = rx_strobes;
        fork
            rx_send(FSI_CH_A, 8'h11);
            begin
                repeat (60) @(negedge clk);
                check("rx_held_not_ready", rx_strobes, s0);
                expect_rx(FSI_CH_A, 8'h11);
                bus.i_rx_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check("rx_11_after_ready", rx_strobes, s0 + 1);

        // channel filter pair
        s0 = rx_strobes;
        expect_rx(FSI_CH_B, 8'h22);
        rx_send(FSI_CH_B, 8'h22);
        expect_rx(FSI_CH_A, 8'h33);
        rx_send(FSI_CH_A, 8'h33);
        repeat (4) @(negedge clk);
`ifdef FTDI_FSI_RX_CHANNEL_FILTER_EN
        check("rx_filter_count", rx_strobes, s0 + 1);
`else
        check("rx_filter_count", rx_strobes, s0 + 2);
`endif

        // reset in the middle of a TX frame
        send_tx(FSI_CH_A, 8'h77);
        lat = 0;
        while (bus.o_ftdi_si && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midtx_rst_si", bus.o_ftdi_si, 1);
        check("midtx_rst_busy", bus.o_tx_busy, 0);
        tx_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // randomized full-duplex traffic
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    gap = $urandom_range(0, 20);
                    repeat (gap) @(negedge clk);
                    if ($urandom_range(0, 3) == 0) begin
                        bus.i_ftdi_cts = 1'b0;
                        gap = $urandom_range(1, 30);
                        repeat (gap) @(negedge clk);
                        bus.i_ftdi_cts = 1'b1;
                    end
                    send_tx(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                end
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    gap = $urandom_range(0, 3);
                    repeat (gap) wait_rise(2000);
                    ch = 1'($urandom_range(0, 1));
                    d  = 8'($urandom_range(0, 255));
                    expect_rx(ch, d);
                    rx_send(ch, d);
                end
            end
        join

        for (int n = 0; n < 3000 && (tx_q.size() != 0 || rx_q.size() != 0 || bus.o_tx_busy); n++)
            @(negedge clk);
        repeat (20) @(negedge clk);
        check("drain_tx_q", tx_q.size(), 0);
        check("drain_rx_q", rx_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
